alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//   Operand-issue stage directly upstream of alu32. Accepts one op per cycle (valid/ready),
//   reads a multi-ported register file and registers alu_a/alu_b/alu_f into alu32.
//   Takes alu32's registered result (alu_y) back and writes it to the register file.
//   Blocks on read-after-write hazards with a stall/scoreboard.
// PARAMETERS
//   W    32  datapath width; must match alu32
//   NREG 8   number of registers; r0 is hardwired to zero
//   AW   3   register address width, with NREG = 2**AW
// PORTS
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   op presented
//   in_ready   out  1   stage can accept; combinational
//   in_f       in   4   ALU function code, passed to alu_f
//   in_rd      in   AW  destination register
//   in_rs1     in   AW  source register for alu_a
//   in_rs2     in   AW  source register for alu_b
//   in_imm_en  in   1   1: alu_b = in_imm instead of reg[rs2]; rs2 is then ignored for hazards
//   in_imm     in   W   immediate value
//   alu_a      out  W   registered operand a to alu32
//   alu_b      out  W   registered operand b to alu32
//   alu_f      out  4   registered function to alu32
//   alu_y      in   W   alu32 registered result
//   dbg_addr   in   AW  debug read address
//   dbg_data   out  W   reg[dbg_addr]; combinational, reads the array only (no bypass)
// BEHAVIOUR
//   Reset (async, rst=1):
//     - all registers = 0
//     - alu_a = alu_b = 0, alu_f = 0
//     - s1_valid = wb_valid = 0
//     - in_ready = 1 whenever no hazard is pending
//   accept = in_valid & in_ready.
//   Pipeline (edge E0 = accept):
//     E0  alu_a <= rdA; alu_b <= in_imm_en ? in_imm : rdB; alu_f <= in_f;
//         s1_valid <= 1, s1_rd <= in_rd. With no accept, s1_valid <= 0 and alu_a/b/f hold.
//     E1  alu32 latches y. wb_valid <= s1_valid & (s1_rd != 0); wb_rd <= s1_rd.
//     E2  if wb_valid: reg[wb_rd] <= alu_y.
//     Latency accept -> register written = 2 edges. Throughput = 1 op/cycle without hazards.
//   rdA/rdB: reg[rs]; reads of r0 return 0. Writes to r0 are dropped; no wb_valid is raised for them.
//   Hazard (in_ready = 0) when a used source rs != 0 matches:
//     - s1_rd while s1_valid; or
//     - wb_rd while wb_valid (only when BYPASS_EN is undefined).
//     rs2 is not a used source when in_imm_en = 1.
//   in_ready depends only on the rs inputs and stage state, not on in_valid (no combinational loop).
//   A stalled op must be held stable by the producer; no op is dropped or duplicated.
//   Reset mid-operation: in-flight s1/wb ops are discarded. A write pending at E2 must not occur.
//     alu32 has no reset, so its stale y is never written.
//   Same-cycle writeback and debug read of the same register: dbg_data shows the old value
//     until after the edge.
//   Widths: all W bits pass through. alu_f is not decoded here.
// CONFIGURATION
//   BYPASS_EN defined:
//     - during a cycle with wb_valid, sources equal to wb_rd take alu_y instead of the array
//     - a dependent op issued back-to-back stalls 1 cycle
//   BYPASS_EN undefined:
//     - no forwarding; hazard also covers wb_rd
//     - a dependent op issued back-to-back stalls 2 cycles (it reads after the E2 write)
// TESTING
//   1. rst pulse mid-cycle -> all outputs 0 immediately, dbg_data = 0 for every addr, in_ready = 1.
//   2. Load r1 = 5 (f=1, rs1=0, imm=5), then r2 = 3; then f=2, rd=3, rs1=1, rs2=2
//      -> alu_a=5, alu_b=3, and dbg r3 = 2 two edges after accept.
//   3. Load r1 = 7, next cycle f=1 rd=2 rs1=1 imm=0 -> in_ready low 1 cycle (BYPASS_EN)
//      or 2 cycles (undefined); r2 = 7; alu_a = 7.
//   4. f=1, imm=9, rd=0; next op reads r0 -> no stall; dbg r0 = 0; alu_a = 0.
//   5. Accept load r1 = 0xDEAD, assert rst at E1 -> r1 stays 0, s1/wb valid = 0.
//   6. 4 independent loads r1..r4 = 1..4 on consecutive cycles -> in_ready stays 1;
//      r1..r4 = 1..4 after 2 more edges.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: producer op handshake, alu32 operand/result path, debug read port.
interface alu_issue_stage_if #(
  parameter int W  = 32,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_f;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic          in_imm_en;
  logic [W-1:0]  in_imm;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_f;
  logic [W-1:0]  alu_y;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  modport master (
    output in_valid, in_f, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, alu_y, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_f, dbg_data
  );

  modport slave (
    input  in_valid, in_f, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, alu_y, dbg_addr,
    output in_ready, alu_a, alu_b, alu_f, dbg_data
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand issue into alu32 with RAW scoreboard and 2-edge writeback of alu_y.
// Optional BYPASS_EN: forward alu_y to sources matching the pending writeback.
module alu_issue_rdport #(
  parameter int W    = 32,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic [NREG-1:0][W-1:0] regs,
  input  logic [AW-1:0]          rs,
  input  logic                   s1_valid,
  input  logic [AW-1:0]          s1_rd,
  input  logic                   wb_valid,
  input  logic [AW-1:0]          wb_rd,
  output logic [W-1:0]           data,
  output logic                   s1_hit,
  output logic                   wb_hit
);
  logic rs_nz;

  // r0 never matches anything: it reads as zero and is never written
  assign rs_nz  = (rs != '0);
  assign data   = rs_nz ? regs[rs] : '0;
  assign s1_hit = rs_nz && s1_valid && (s1_rd == rs);
  assign wb_hit = rs_nz && wb_valid && (wb_rd == rs);
endmodule

module alu_issue_stage #(
  parameter int W    = 32,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave bus
);
  localparam int NPORT  = 2;
  localparam int STAGES = 1;
`ifdef BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]    f;
    logic [AW-1:0] rd;
    logic          imm_en;
    logic [W-1:0]  imm;
  } req_t;

  req_t                        req;
  logic [NREG-1:0][W-1:0]      regs;
  logic [NPORT-1:0][AW-1:0]    rs;
  logic [NPORT-1:0]            used;
  logic [NPORT-1:0]            s1_hit;
  logic [NPORT-1:0]            wb_hit;
  logic [NPORT-1:0]            hazard;
  logic [NPORT-1:0][W-1:0]     raw;
  logic [NPORT-1:0][W-1:0]     src;
  // vld_pipe[0] = s1_valid (op in alu32), vld_pipe[1] = wb_valid (result due next edge)
  logic [STAGES:0]             vld_pipe;
  logic [AW-1:0]               s1_rd;
  logic [AW-1:0]               wb_rd;
  logic [W-1:0]                alu_a_q;
  logic [W-1:0]                alu_b_q;
  logic [3:0]                  alu_f_q;
  logic                        accept;

  assign req    = '{f: bus.in_f, rd: bus.in_rd, imm_en: bus.in_imm_en, imm: bus.in_imm};
  assign rs     = {bus.in_rs2, bus.in_rs1};
  assign used   = {~req.imm_en, 1'b1};

  generate
    for (genvar p = 0; p < NPORT; p++) begin : g_port
      alu_issue_rdport #(.W(W), .NREG(NREG), .AW(AW)) u_port (
        .regs     (regs),
        .rs       (rs[p]),
        .s1_valid (vld_pipe[0]),
        .s1_rd    (s1_rd),
        .wb_valid (vld_pipe[1]),
        .wb_rd    (wb_rd),
        .data     (raw[p]),
        .s1_hit   (s1_hit[p]),
        .wb_hit   (wb_hit[p])
      );
      // with forwarding the writeback stage is no longer a hazard
      assign hazard[p] = used[p] & (s1_hit[p] | (~BYPASS & wb_hit[p]));
      assign src[p]    = (BYPASS && wb_hit[p]) ? bus.alu_y : raw[p];
    end
  endgenerate

  assign bus.in_ready = ~|hazard;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_rd    <= '0;
      wb_rd    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_f_q  <= '0;
      regs     <= '0;
    end else begin
      vld_pipe[0] <= accept;
      vld_pipe[1] <= vld_pipe[0] && (s1_rd != '0);
      wb_rd       <= s1_rd;
      if (accept) begin
        s1_rd   <= req.rd;
        alu_a_q <= src[0];
        alu_b_q <= req.imm_en ? req.imm : src[1];
        alu_f_q <= req.f;
      end
      if (vld_pipe[1]) regs[wb_rd] <= bus.alu_y;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_f    = alu_f_q;
  assign bus.dbg_data = regs[bus.dbg_addr];
endmodule
